hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard detector: tracks in-flight destinations, raises stall/flush and selects forwarding sources.
// Build option: define HAZARD_FORWARDING_EN to forward results and stall only on load-use.
module hazard_unit #(
    parameter int STAGES     = 3,
    parameter int REG_ADDR_W = 5,
    localparam int SEL_W     = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic                  flush,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [SEL_W-1:0]      fwd_sel2,
    output logic [15:0]           stall_count
);

    logic [STAGES-1:0]                 valid_q, valid_d;
    logic [STAGES-1:0]                 rw_q, rw_d;
    logic [STAGES-1:0]                 mr_q, mr_d;
    logic [STAGES-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
    logic [15:0]                       cnt_q, cnt_d;

    logic             hit1, hit2;
    logic [SEL_W-1:0] idx1, idx2;
    logic             hazard;
    logic [SEL_W-1:0] sel1, sel2;

    // Scan oldest to youngest so the lowest matching index is what remains.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx1 = '0;
        idx2 = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (id_use_rs1 && (id_rs1 != '0) && valid_q[k] && rw_q[k] && (rd_q[k] == id_rs1)) begin
                hit1 = 1'b1;
                idx1 = SEL_W'(k);
            end
            if (id_use_rs2 && (id_rs2 != '0) && valid_q[k] && rw_q[k] && (rd_q[k] == id_rs2)) begin
                hit2 = 1'b1;
                idx2 = SEL_W'(k);
            end
        end
    end

`ifdef HAZARD_FORWARDING_EN
    always_comb begin
        hazard = (hit1 && (idx1 == '0) && mr_q[0]) || (hit2 && (idx2 == '0) && mr_q[0]);
        sel1   = hit1 ? idx1 + SEL_W'(1) : '0;
        sel2   = hit2 ? idx2 + SEL_W'(1) : '0;
    end
`else
    logic unused_nofwd;
    assign unused_nofwd = ^{mr_q, idx1, idx2};

    always_comb begin
        hazard = hit1 || hit2;
        sel1   = '0;
        sel2   = '0;
    end
`endif

    // Outputs are held low during reset; a taken branch overrides any hazard.
    always_comb begin
        stall    = rst && id_valid && !branch_taken && hazard;
        flush    = rst && branch_taken;
        fwd_sel1 = (rst && id_valid) ? sel1 : '0;
        fwd_sel2 = (rst && id_valid) ? sel2 : '0;
    end

    always_comb begin
        valid_d    = valid_q;
        rw_d       = rw_q;
        mr_d       = mr_q;
        rd_d       = rd_q;
        valid_d[0] = id_valid && !stall && !branch_taken;
        rw_d[0]    = id_reg_write;
        mr_d[0]    = id_mem_read;
        rd_d[0]    = id_rd;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            rw_d[k]    = rw_q[k-1];
            mr_d[k]    = mr_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
        cnt_d = cnt_q;
        if (stall && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload fields are only meaningful alongside valid, so they need no reset.
    always_ff @(posedge clk) begin
        rw_q <= rw_d;
        mr_q <= mr_d;
        rd_q <= rd_d;
    end

    assign stall_count = cnt_q;

endmodule
